mem_cpu_access_master: RTL and testbench



---
 rtl/mem_cpu_access_master.sv | 148 ++++++++++++++
 tb/tb_mem_cpu_access_master.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_cpu_access_master.sv
// Host register-bus to memory-controller cpu-port initiator: one host access becomes one
// edge-detected memory request, answered by read data, a write completion or a timeout error.
module mem_cpu_access_master #(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned TIMEOUT    = 255,
   parameter int unsigned GAP_CYCLES = 2
) (
   input  logic                  clockCore,
   input  logic                  resetCore,
   input  logic                  hostReqValid,
   output logic                  hostReqReady,
   input  logic                  hostRd,
   input  logic [ADDR_WIDTH-1:0] hostAddr,
   input  logic [DATA_WIDTH-1:0] hostWrData,
   output logic                  hostRspValid,
   output logic                  hostRspErr,
   output logic [DATA_WIDTH-1:0] hostRspRdData,
   output logic                  staleAck,
   output logic                  cpuMemReq,
   output logic                  cpuMemRd,
   output logic [ADDR_WIDTH-1:0] cpuMemAddr,
   output logic [DATA_WIDTH-1:0] cpuMemWrData,
   input  logic                  cpuMemAck,
   input  logic [DATA_WIDTH-1:0] cpuMemRdData
);

   localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);
   localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);
   localparam int unsigned CNT_W = (TO_W > GAP_W) ? TO_W : GAP_W;
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_GAP  = 2'd0,
      ST_IDLE = 2'd1,
      ST_WAIT = 2'd2
   } stateT;

   stateT                 state,           stateNxt;
   logic [CNT_W-1:0]      cnt,             cntNxt;
   logic                  hostReqReadyNxt;
   logic                  cpuMemReqNxt;
   logic                  cpuMemRdNxt;
   logic [ADDR_WIDTH-1:0] cpuMemAddrNxt;
   logic [DATA_WIDTH-1:0] cpuMemWrDataNxt;
   logic                  hostRspValidNxt;
   logic                  hostRspErrNxt;
   logic [DATA_WIDTH-1:0] hostRspRdDataNxt;
   logic                  staleAckNxt;

   // State and every output are registered; reset parks the FSM in GAP so the
   // controller's edge detector settles before the first request.
   always_ff @(posedge clockCore or negedge resetCore) begin
      if (!resetCore) begin
         state         <= ST_GAP;
         cnt           <= '0;
         hostReqReady  <= 1'b0;
         cpuMemReq     <= 1'b0;
         cpuMemRd      <= 1'b0;
         cpuMemAddr    <= '0;
         cpuMemWrData  <= '0;
         hostRspValid  <= 1'b0;
         hostRspErr    <= 1'b0;
         hostRspRdData <= '0;
         staleAck      <= 1'b0;
      end else begin
         state         <= stateNxt;
         cnt           <= cntNxt;
         hostReqReady  <= hostReqReadyNxt;
         cpuMemReq     <= cpuMemReqNxt;
         cpuMemRd      <= cpuMemRdNxt;
         cpuMemAddr    <= cpuMemAddrNxt;
         cpuMemWrData  <= cpuMemWrDataNxt;
         hostRspValid  <= hostRspValidNxt;
         hostRspErr    <= hostRspErrNxt;
         hostRspRdData <= hostRspRdDataNxt;
         staleAck      <= staleAckNxt;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      stateNxt         = state;
      cntNxt           = cnt;
      hostReqReadyNxt  = 1'b0;
      cpuMemReqNxt     = cpuMemReq;
      cpuMemRdNxt      = cpuMemRd;
      cpuMemAddrNxt    = cpuMemAddr;
      cpuMemWrDataNxt  = cpuMemWrData;
      hostRspValidNxt  = 1'b0;
      hostRspErrNxt    = 1'b0;
      hostRspRdDataNxt = hostRspRdData;
      // An ack we are not waiting for is never matched to a later access
      staleAckNxt      = staleAck | (cpuMemAck && (state != ST_WAIT));

      unique case (state)
         ST_GAP: begin
            cpuMemReqNxt = 1'b0;
            if (cnt == GAP_LAST) begin
               stateNxt        = ST_IDLE;
               cntNxt          = '0;
               hostReqReadyNxt = 1'b1;
            end else begin
               cntNxt = cnt + CNT_W'(1);
            end
         end
         ST_IDLE: begin
            hostReqReadyNxt = 1'b1;
            if (hostReqValid && hostReqReady) begin
               hostReqReadyNxt = 1'b0;
               cpuMemReqNxt    = 1'b1;
               cpuMemRdNxt     = hostRd;
               cpuMemAddrNxt   = hostAddr;
               cpuMemWrDataNxt = hostWrData;
               cntNxt          = '0;
               stateNxt        = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // Ack takes precedence over a timeout landing in the same cycle
            if (cpuMemAck) begin
               cpuMemReqNxt    = 1'b0;
               hostRspValidNxt = 1'b1;
               if (cpuMemRd) begin
                  hostRspRdDataNxt = cpuMemRdData;
               end
               cntNxt   = '0;
               stateNxt = ST_GAP;
            end else if (cnt == TIMEOUT_LAST) begin
               cpuMemReqNxt    = 1'b0;
               hostRspValidNxt = 1'b1;
               hostRspErrNxt   = 1'b1;
               cntNxt          = '0;
               stateNxt        = ST_GAP;
            end else begin
               cntNxt = cnt + CNT_W'(1);
            end
         end
         default: begin
            cpuMemReqNxt = 1'b0;
            cntNxt       = '0;
            stateNxt     = ST_GAP;
         end
      endcase
   end

endmodule

// File: tb/tb_mem_cpu_access_master.sv
// Self-checking bench for mem_cpu_access_master: vector table, corner sequences and
// randomized accesses against a rule-level model of request length, error and read data.
module tb_mem_cpu_access_master;

   localparam int unsigned AW  = 8;
   localparam int unsigned DW  = 16;
   localparam int unsigned TO  = 8;
   localparam int unsigned GAP = 2;

   logic          clockCore = 1'b0;
   logic          resetCore;
   logic          hostReqValid;
   logic          hostReqReady;
   logic          hostRd;
   logic [AW-1:0] hostAddr;
   logic [DW-1:0] hostWrData;
   logic          hostRspValid;
   logic          hostRspErr;
   logic [DW-1:0] hostRspRdData;
   logic          staleAck;
   logic          cpuMemReq;
   logic          cpuMemRd;
   logic [AW-1:0] cpuMemAddr;
   logic [DW-1:0] cpuMemWrData;
   logic          cpuMemAck;
   logic [DW-1:0] cpuMemRdData;

   mem_cpu_access_master #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO), .GAP_CYCLES(GAP)
   ) dut (
      .clockCore(clockCore), .resetCore(resetCore),
      .hostReqValid(hostReqValid), .hostReqReady(hostReqReady),
      .hostRd(hostRd), .hostAddr(hostAddr), .hostWrData(hostWrData),
      .hostRspValid(hostRspValid), .hostRspErr(hostRspErr),
      .hostRspRdData(hostRspRdData), .staleAck(staleAck),
      .cpuMemReq(cpuMemReq), .cpuMemRd(cpuMemRd), .cpuMemAddr(cpuMemAddr),
      .cpuMemWrData(cpuMemWrData), .cpuMemAck(cpuMemAck), .cpuMemRdData(cpuMemRdData)
   );

   always #5 clockCore = ~clockCore;

   typedef struct {
      logic          rd;
      logic [AW-1:0] addr;
      logic [DW-1:0] wd;
      int            ackAt;
      logic [DW-1:0] rdVal;
      logic          expErr;
      int            expHigh;
      logic [DW-1:0] expRd;
   } vecT;

   vecT  vecs[6];
   int   checks   = 0;
   int   failures = 0;
   int   lowRun   = 0;
   int   gapSeen  = 0;
   logic prevReq  = 1'b0;
   bit   expStale = 1'b0;
   logic [DW-1:0] modelRd = '0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic checkMin(input string nm, input int act, input int minVal);
      checks++;
      if (act < minVal) begin
         failures++;
         $display("FAIL %s actual=%0d required>=%0d", nm, act, minVal);
      end
   endtask

   task automatic checkAllZero(input string nm);
      check({nm, "_ready"},  32'(hostReqReady), 32'(0));
      check({nm, "_req"},    32'(cpuMemReq),    32'(0));
      check({nm, "_rd"},     32'(cpuMemRd),     32'(0));
      check({nm, "_addr"},   32'(cpuMemAddr),   32'(0));
      check({nm, "_wd"},     32'(cpuMemWrData), 32'(0));
      check({nm, "_rspV"},   32'(hostRspValid), 32'(0));
      check({nm, "_rspE"},   32'(hostRspErr),   32'(0));
      check({nm, "_rspD"},   32'(hostRspRdData), 32'(0));
      check({nm, "_stale"},  32'(staleAck),     32'(0));
   endtask

   // Advance to the next falling edge and track how long cpuMemReq stayed low
   task automatic tick();
      @(negedge clockCore);
      if (cpuMemReq) begin
         if (!prevReq) gapSeen = lowRun;
         lowRun = 0;
      end else begin
         lowRun++;
      end
      prevReq = cpuMemReq;
   endtask

   task automatic doAccess(input string nm, input logic rd, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wd, input int ackAt, input logic [DW-1:0] rdVal,
                           input logic expErr, input int expHigh, input logic [DW-1:0] expRd,
                           input bit checkGap);
      int n;
      int highCnt;
      hostReqValid = 1'b1;
      hostRd       = rd;
      hostAddr     = addr;
      hostWrData   = wd;
      n = 0;
      while (!hostReqReady && n < 50) begin
         tick();
         n++;
      end
      check({nm, "_readyWait"}, 32'(hostReqReady), 32'(1));
      tick();
      if (checkGap) checkMin({nm, "_gapLow"}, gapSeen, int'(GAP) + 1);
      // Host keeps valid high with different fields; the block must ignore it while busy
      hostRd     = ~rd;
      hostAddr   = ~addr;
      hostWrData = ~wd;
      highCnt = 0;
      while (cpuMemReq && highCnt < int'(TO) + 4) begin
         highCnt++;
         check({nm, "_memRd"},   32'(cpuMemRd),     32'(rd));
         check({nm, "_memAddr"}, 32'(cpuMemAddr),   32'(addr));
         check({nm, "_memWd"},   32'(cpuMemWrData), 32'(wd));
         check({nm, "_busyRdy"}, 32'(hostReqReady), 32'(0));
         check({nm, "_earlyRsp"}, 32'(hostRspValid), 32'(0));
         cpuMemAck    = (highCnt == ackAt);
         cpuMemRdData = (highCnt == ackAt) ? rdVal : DW'($urandom);
         tick();
      end
      cpuMemAck    = 1'b0;
      hostReqValid = 1'b0;
      check({nm, "_highCycles"}, 32'(highCnt),       32'(expHigh));
      check({nm, "_rspValid"},   32'(hostRspValid),  32'(1));
      check({nm, "_rspErr"},     32'(hostRspErr),    32'(expErr));
      check({nm, "_rspData"},    32'(hostRspRdData), 32'(expRd));
      check({nm, "_gapRdy"},     32'(hostReqReady),  32'(0));
      check({nm, "_stale"},      32'(staleAck),      32'(expStale));
      tick();
      check({nm, "_rspPulse"},   32'(hostRspValid),  32'(0));
      check({nm, "_rspHold"},    32'(hostRspRdData), 32'(expRd));
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int ackAt;
      logic rd;
      logic expErr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wd;
      logic [DW-1:0] rdVal;

      vecs[0] = '{1'b0, 8'h12, 16'hA5A5, 4, 16'h1111, 1'b0, 4, 16'h0000};
      vecs[1] = '{1'b1, 8'h34, 16'h0000, 3, 16'hBEEF, 1'b0, 3, 16'hBEEF};
      vecs[2] = '{1'b0, 8'h56, 16'h1234, 1, 16'h2222, 1'b0, 1, 16'hBEEF};
      vecs[3] = '{1'b1, 8'h9A, 16'h3333, 8, 16'hCAFE, 1'b0, 8, 16'hCAFE};
      vecs[4] = '{1'b0, 8'hBC, 16'h4444, 9, 16'h5555, 1'b1, 8, 16'hCAFE};
      vecs[5] = '{1'b1, 8'hDE, 16'h6666, 0, 16'h7777, 1'b1, 8, 16'hCAFE};

      resetCore    = 1'b0;
      hostReqValid = 1'b0;
      hostRd       = 1'b0;
      hostAddr     = '0;
      hostWrData   = '0;
      cpuMemAck    = 1'b0;
      cpuMemRdData = '0;
      tick();
      tick();
      checkAllZero("reset");
      resetCore = 1'b1;
      n = 0;
      while (!hostReqReady && n < 10) begin
         tick();
         n++;
      end
      check("resetReadyDelay", 32'(n), 32'(GAP));

      for (int i = 0; i < 6; i++) begin
         doAccess($sformatf("vec%0d", i), vecs[i].rd, vecs[i].addr, vecs[i].wd, vecs[i].ackAt,
                  vecs[i].rdVal, vecs[i].expErr, vecs[i].expHigh, vecs[i].expRd, i != 0);
      end
      modelRd = 16'hCAFE;

      // Timeout followed by a late ack: flagged as stale, no extra response
      doAccess("lateAckTo", 1'b1, 8'h78, 16'h0000, 0, 16'hDEAD, 1'b1, TO, modelRd, 1'b1);
      repeat (4) tick();
      cpuMemAck    = 1'b1;
      cpuMemRdData = 16'h5A5A;
      tick();
      cpuMemAck = 1'b0;
      expStale  = 1'b1;
      n = 0;
      for (int i = 0; i < 6; i++) begin
         if (hostRspValid) n++;
         tick();
      end
      check("lateAckNoRsp", 32'(n), 32'(0));
      check("lateAckStale", 32'(staleAck), 32'(1));
      check("lateAckData",  32'(hostRspRdData), 32'(modelRd));

      // Reset in the middle of a WAIT
      hostReqValid = 1'b1;
      hostRd       = 1'b0;
      hostAddr     = 8'hC3;
      hostWrData   = 16'h0F0F;
      n = 0;
      while (!hostReqReady && n < 50) begin
         tick();
         n++;
      end
      tick();
      hostReqValid = 1'b0;
      tick();
      check("midRstPreReq", 32'(cpuMemReq), 32'(1));
      #2 resetCore = 1'b0;
      #1;
      checkAllZero("midRst");
      tick();
      resetCore = 1'b1;
      modelRd   = '0;
      cpuMemAck = 1'b1;
      n = 0;
      tick();
      n++;
      cpuMemAck = 1'b0;
      while (!hostReqReady && n < 10) begin
         tick();
         n++;
      end
      expStale = 1'b1;
      check("midRstReadyDelay", 32'(n), 32'(GAP));
      check("midRstStale",      32'(staleAck), 32'(1));
      check("midRstNoRsp",      32'(hostRspValid), 32'(0));
      doAccess("afterRst", 1'b0, 8'h21, 16'h1357, 2, 16'h9999, 1'b0, 2, modelRd, 1'b0);

      // Randomized accesses against the rule-level model
      for (int i = 0; i < 40; i++) begin
         rd     = 1'($urandom);
         addr   = AW'($urandom);
         wd     = DW'($urandom);
         rdVal  = DW'($urandom);
         ackAt  = int'($urandom_range(0, 10));
         expErr = (ackAt < 1) || (ackAt > int'(TO));
         if (!expErr && rd) modelRd = rdVal;
         doAccess($sformatf("rnd%0d", i), rd, addr, wd, ackAt, rdVal, expErr,
                  expErr ? int'(TO) : ackAt, modelRd, 1'b1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
